// File: rtl/timing_bus_pkg.sv
// Timing bus bit map, shared by the generator and the board-side splitter.
// Bit 1 is reserved and always driven low.
package timing_bus_pkg;
    localparam int BUS_W    = 8;
    localparam int BIT_CLK5 = 0;
    localparam int BIT_RSV  = 1;
    localparam int BIT_TNC  = 2;
    localparam int BIT_TNO  = 3;
    localparam int BIT_TNP  = 4;
    localparam int BIT_TKP  = 5;
    localparam int BIT_TNI  = 6;
    localparam int BIT_TKI  = 7;
endpackage

// File: rtl/tick_div.sv
// Divides clk to the 5 MHz bus period: 50% duty level plus a period-wrap tick.
// clk5 and wrap describe the divider value being loaded on the coming edge.
module tick_div #(
    parameter int DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic clk5,
    output logic wrap
);
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(DIV / 2);

    logic [DW-1:0] d;
    logic [DW-1:0] d_nxt;

    always_comb begin
        d_nxt = d;
        wrap  = 1'b0;
        if (!run || clr) begin
            d_nxt = '0;
        end else if (d == D_LAST) begin
            d_nxt = '0;
            wrap  = 1'b1;
        end else begin
            d_nxt = d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) d <= '0;
        else     d <= d_nxt;
    end

    assign clk5 = (d_nxt < D_HALF);
endmodule

// File: rtl/timing_bus_gen.sv
// Master timing generator: 5 MHz bus clock plus frame/packet/interval strobes.
// Strobes are decoded from the next (t, interval) state so they align with bus[0].
module timing_bus_gen
    import timing_bus_pkg::*;
#(
    parameter int DIV       = 20,
    parameter int FRAME_LEN = 5000,
    parameter int TNO_OFS   = 1,
    parameter int PKT_OFS   = 100,
    parameter int PKT_LEN   = 4000,
    parameter int INT_LEN   = 400,
    parameter int N_INT     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sync_in,
    output logic [BUS_W-1:0]  bus_clk,
    output logic [15:0]       frame_cnt,
    output logic              running
);
    localparam int TW = $clog2(FRAME_LEN);
    localparam int IW = $clog2(INT_LEN);
    localparam int KW = (N_INT > 1) ? $clog2(N_INT) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] T_TNO  = TW'(TNO_OFS);
    localparam logic [TW-1:0] T_TNP  = TW'(PKT_OFS);
    localparam logic [TW-1:0] T_TKP  = TW'(PKT_OFS + PKT_LEN - 1);
    localparam logic [IW-1:0] I_LAST = IW'(INT_LEN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_INT - 1);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("timing_bus_gen: DIV must be even and >= 2");
    end
    if (FRAME_LEN < 2 || TNO_OFS >= FRAME_LEN) begin : g_bad_frame
        $error("timing_bus_gen: bad FRAME_LEN/TNO_OFS");
    end
    if (PKT_LEN < 1 || PKT_OFS + PKT_LEN > FRAME_LEN) begin : g_bad_pkt
        $error("timing_bus_gen: packet does not fit in frame");
    end
    if (INT_LEN < 2 || N_INT < 1 || N_INT * INT_LEN > PKT_LEN) begin : g_bad_int
        $error("timing_bus_gen: bad interval parameters");
    end

    logic              clk5;
    logic              wrap;
    logic              clr;
    logic [TW-1:0]     t;
    logic [TW-1:0]     t_nxt;
    logic              in_int;
    logic              in_int_nxt;
    logic [IW-1:0]     ic;
    logic [IW-1:0]     ic_nxt;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_nxt;
    logic              fc_inc;
    logic [BUS_W-1:0]  bus_nxt;

    // Start from idle and a resync share the same restart path.
    assign clr = !running || sync_in;

    tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (enable),
        .clr  (clr),
        .clk5 (clk5),
        .wrap (wrap)
    );

    always_comb begin
        t_nxt      = t;
        in_int_nxt = in_int;
        ic_nxt     = ic;
        k_nxt      = k;
        fc_inc     = 1'b0;
        if (!enable) begin
            t_nxt      = '0;
            in_int_nxt = 1'b0;
            ic_nxt     = '0;
            k_nxt      = '0;
        end else if (clr || wrap) begin
            if (clr) begin
                t_nxt = '0;
            end else if (t == T_LAST) begin
                t_nxt  = '0;
                fc_inc = 1'b1;
            end else begin
                t_nxt = t + 1'b1;
            end
            if (clr) begin
                in_int_nxt = 1'b0;
                ic_nxt     = '0;
                k_nxt      = '0;
            end else if (in_int) begin
                if (ic == I_LAST) begin
                    ic_nxt = '0;
                    if (k == K_LAST) in_int_nxt = 1'b0;
                    else             k_nxt      = k + 1'b1;
                end else begin
                    ic_nxt = ic + 1'b1;
                end
            end
            if (t_nxt == T_TNP) begin
                in_int_nxt = 1'b1;
                ic_nxt     = '0;
                k_nxt      = '0;
            end
        end
    end

    always_comb begin
        bus_nxt = '0;
        if (enable) begin
            bus_nxt[BIT_CLK5] = clk5;
            bus_nxt[BIT_RSV]  = 1'b0;
            bus_nxt[BIT_TNC]  = (t_nxt == '0);
            bus_nxt[BIT_TNO]  = (t_nxt == T_TNO);
            bus_nxt[BIT_TNP]  = (t_nxt == T_TNP);
            bus_nxt[BIT_TKP]  = (t_nxt == T_TKP);
            bus_nxt[BIT_TNI]  = in_int_nxt && (ic_nxt == '0);
            bus_nxt[BIT_TKI]  = in_int_nxt && (ic_nxt == I_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t         <= '0;
            in_int    <= 1'b0;
            ic        <= '0;
            k         <= '0;
            running   <= 1'b0;
            bus_clk   <= '0;
            frame_cnt <= '0;
        end else begin
            t       <= t_nxt;
            in_int  <= in_int_nxt;
            ic      <= ic_nxt;
            k       <= k_nxt;
            running <= enable;
            bus_clk <= bus_nxt;
            if (fc_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_timing_bus_gen.sv
// Bench for timing_bus_gen: frame-position model plus directed literal checks.
// A second instance with TNO_OFS=5 covers coincident strobes.
module tb_timing_bus_gen;
    localparam int DIV       = 4;
    localparam int FRAME_LEN = 20;
    localparam int TNO_OFS   = 2;
    localparam int PKT_OFS   = 5;
    localparam int PKT_LEN   = 10;
    localparam int INT_LEN   = 3;
    localparam int N_INT     = 3;
    localparam int TNO_B     = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sync_in;
    logic [7:0]  bus_a;
    logic [7:0]  bus_b;
    logic [15:0] fc_a;
    logic [15:0] fc_b;
    logic        run_a;
    logic        run_b;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    // model state: position in frame, not the RTL's registers
    bit          m_run = 1'b0;
    int          m_d   = 0;
    int          m_t   = 0;
    logic [15:0] m_fc  = '0;

    always #5 clk = ~clk;

    timing_bus_gen #(
        .DIV(DIV), .FRAME_LEN(FRAME_LEN), .TNO_OFS(TNO_OFS),
        .PKT_OFS(PKT_OFS), .PKT_LEN(PKT_LEN),
        .INT_LEN(INT_LEN), .N_INT(N_INT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sync_in(sync_in),
        .bus_clk(bus_a), .frame_cnt(fc_a), .running(run_a)
    );

    timing_bus_gen #(
        .DIV(DIV), .FRAME_LEN(FRAME_LEN), .TNO_OFS(TNO_B),
        .PKT_OFS(PKT_OFS), .PKT_LEN(PKT_LEN),
        .INT_LEN(INT_LEN), .N_INT(N_INT)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .sync_in(sync_in),
        .bus_clk(bus_b), .frame_cnt(fc_b), .running(run_b)
    );

    task automatic check(input string nm,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_bus(int t, int d, int tno);
        logic [7:0] b;
        b = 8'h00;
        b[0] = (d < DIV / 2);
        b[2] = (t == 0);
        b[3] = (t == tno);
        b[4] = (t == PKT_OFS);
        b[5] = (t == PKT_OFS + PKT_LEN - 1);
        for (int k = 0; k < N_INT; k++) begin
            if (t == PKT_OFS + k * INT_LEN) b[6] = 1'b1;
            if (t == PKT_OFS + k * INT_LEN + INT_LEN - 1) b[7] = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_d = 0; m_t = 0; m_fc = '0;
        end else if (!enable) begin
            m_run = 1'b0; m_d = 0; m_t = 0;
        end else if (!m_run || sync_in) begin
            m_run = 1'b1; m_d = 0; m_t = 0;
        end else if (m_d == DIV - 1) begin
            m_d = 0;
            if (m_t == FRAME_LEN - 1) begin
                m_t = 0;
                m_fc = m_fc + 16'd1;
            end else begin
                m_t = m_t + 1;
            end
        end else begin
            m_d = m_d + 1;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("bus_a", 16'(bus_a),
                  m_run ? 16'(exp_bus(m_t, m_d, TNO_OFS)) : 16'h0);
            check("bus_b", 16'(bus_b),
                  m_run ? 16'(exp_bus(m_t, m_d, TNO_B)) : 16'h0);
            check("run_a", 16'(run_a), 16'(m_run));
            check("run_b", 16'(run_b), 16'(m_run));
            check("fc_a", fc_a, m_fc);
            check("fc_b", fc_b, m_fc);
        end
    end

    task automatic wait_t(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (m_run && m_t == n && m_d == 0) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL wait_t: t=%0d not reached, want %0d", m_t, n);
        end
    endtask

    logic [7:0] seq [9] = '{8'h05, 8'h05, 8'h04, 8'h04,
                            8'h01, 8'h01, 8'h00, 8'h00, 8'h09};

    initial begin
        rst = 1'b1; enable = 1'b0; sync_in = 1'b0;
        repeat (2) @(negedge clk);
        chk = 1'b1;
        check("rst_bus", 16'(bus_a), 16'h00);
        check("rst_fc", fc_a, 16'h0);
        check("rst_run", 16'(run_a), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_bus", 16'(bus_a), 16'h00);

        // scenario 1/2: start and one frame of strobes
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("start_seq", 16'(bus_a), 16'(seq[i]));
        end
        wait_t(5);
        check("t5_a", 16'(bus_a), 16'h51);
        check("t5_b", 16'(bus_b), 16'h59);
        wait_t(7);  check("t7", 16'(bus_a), 16'h81);
        wait_t(8);  check("t8", 16'(bus_a), 16'h41);
        wait_t(9);  check("t9", 16'(bus_a), 16'h01);
        wait_t(10); check("t10", 16'(bus_a), 16'h81);
        wait_t(11); check("t11", 16'(bus_a), 16'h41);
        wait_t(13); check("t13", 16'(bus_a), 16'h81);
        wait_t(14); check("t14", 16'(bus_a), 16'h21);
        wait_t(0);
        check("wrap_bus", 16'(bus_a), 16'h05);
        check("wrap_fc", fc_a, 16'h1);

        // scenario 3: resync at t=9
        wait_t(9);
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        check("sync_bus", 16'(bus_a), 16'h05);
        check("sync_fc", fc_a, 16'h1);
        wait_t(5); check("sync_t5", 16'(bus_a), 16'h51);
        wait_t(8); check("sync_t8", 16'(bus_a), 16'h41);
        wait_t(0); check("sync_fc2", fc_a, 16'h2);

        // scenario 4: drop enable mid-packet
        wait_t(6);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bus", 16'(bus_a), 16'h00);
        check("dis_run", 16'(run_a), 16'h0);
        enable = 1'b1;
        @(negedge clk);
        check("ren_bus", 16'(bus_a), 16'h05);
        check("ren_fc", fc_a, 16'h2);

        // scenario 5: reset mid-frame while enabled
        wait_t(6);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_bus", 16'(bus_a), 16'h00);
        check("mrst_fc", fc_a, 16'h0);
        check("mrst_run", 16'(run_a), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_start", 16'(bus_a), 16'h05);
        check("mrst_run1", 16'(run_a), 16'h1);

        // scenario 6: frame counter wrap via preload
        wait_t(3);
        force dut.frame_cnt = 16'hFFFF;
        force dut2.frame_cnt = 16'hFFFF;
        m_fc = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        release dut2.frame_cnt;
        wait_t(0);
        check("fc_wrap", fc_a, 16'h0);

        // sync while idle is ignored
        enable = 1'b0;
        @(negedge clk);
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        check("idle_sync_bus", 16'(bus_a), 16'h00);
        check("idle_sync_run", 16'(run_a), 16'h0);
        @(negedge clk);
        chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
